banked_sp_reg: RTL

Multi-bank stack pointer register with per-bank lower limit, sticky overflow/underflow fault tracking and a configurable push/pop step. It is the next generation of the single stack pointer and keeps its pre-decrement/post-increment semantics. It sits on the CPU register file's two tri-state buses `a`/`b`. It lets the control unit switch stacks per privilege mode and trap on stack faults instead of silently wrapping.

---
 rtl/sp_pkg.sv | 9 +
 rtl/banked_sp_reg_if.sv | 29 ++
 rtl/sp_bank.sv | 55 +++++
 rtl/banked_sp_reg.sv | 50 +++++
 4 files changed

// File: rtl/sp_pkg.sv
// sp_pkg: shared types, fault-cause codes and width helper for the banked stack pointer
package sp_pkg;
  typedef enum logic {SP_OK, SP_FAULT} sp_state_e;
  localparam logic SP_CAUSE_UDF = 1'b0;
  localparam logic SP_CAUSE_OVF = 1'b1;
  function automatic int SP_SEL_W(input int banks);
    return banks > 1 ? $clog2(banks) : 1;
  endfunction
endpackage

// File: rtl/banked_sp_reg_if.sv
// banked_sp_reg_if: control/status bundle between the control unit and the banked stack pointer
interface banked_sp_reg_if
  import sp_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int BANKS = 2
);
  logic [SIZE-1:0]             in;
  logic [SIZE-1:0]             value;
  logic                        oe_a;
  logic                        oe_b;
  logic                        ld;
  logic                        ld_limit;
  logic                        post_inc;
  logic                        pre_dec;
  logic                        clr_fault;
  logic                        trap;
  logic [SP_SEL_W(BANKS)-1:0]  bank_sel;
  logic [BANKS-1:0]            fault;
  logic [BANKS-1:0]            fault_ovf;
  modport master (
    output in, oe_a, oe_b, ld, ld_limit, post_inc, pre_dec, clr_fault, bank_sel,
    input  value, trap, fault, fault_ovf
  );
  modport slave (
    input  in, oe_a, oe_b, ld, ld_limit, post_inc, pre_dec, clr_fault, bank_sel,
    output value, trap, fault, fault_ovf
  );
endinterface

// File: rtl/sp_bank.sv
// sp_bank: one stack pointer with lower limit, bounds check and sticky OK/FAULT state
module sp_bank
  import sp_pkg::*;
#(
  parameter int              SIZE          = 32,
  parameter int              STEP          = 1,
  parameter logic [SIZE-1:0] INITIAL_VAL   = '0,
  parameter logic [SIZE-1:0] INITIAL_LIMIT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sel,
  input  logic [SIZE-1:0] in,
  input  logic            ld,
  input  logic            ld_limit,
  input  logic            post_inc,
  input  logic            pre_dec,
  input  logic            clr_fault,
  output logic [SIZE-1:0] ptr,
  output logic            trap,
  output logic            fault,
  output logic            fault_ovf
);
  localparam logic signed [SIZE+1:0] ST = (SIZE+2)'(STEP);
  sp_state_e state, state_d;
  logic [SIZE-1:0] limit;
  logic signed [SIZE+1:0] nxt;
  logic chk, below;
  assign nxt = $signed({2'b00, ld ? in : ptr}) + (post_inc ? ST : '0) - (pre_dec ? ST : '0);
  assign chk = sel && (pre_dec ^ post_inc) && state == SP_OK && !clr_fault;
  assign below = nxt < $signed({2'b00, limit});
  assign trap = chk && (below || nxt[SIZE+1:SIZE] == 2'b01);
  assign fault = state == SP_FAULT;
  // next state: a trap faults the bank, a selected clear returns it to OK
  always_comb begin
    state_d = state;
    state_d = state == SP_OK ? (trap ? SP_FAULT : SP_OK) : (sel && clr_fault ? SP_OK : SP_FAULT);
  end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= SP_OK;
    else state <= state_d;
  // pointer, limit and fault cause; a trapping op leaves the pointer untouched
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= INITIAL_VAL;
      limit <= INITIAL_LIMIT;
      fault_ovf <= SP_CAUSE_UDF;
    end else begin
      if (sel && !trap && (ld || chk)) ptr <= chk ? nxt[SIZE-1:0] : in;
      if (sel && ld_limit) limit <= in;
      if (trap) fault_ovf <= below ? SP_CAUSE_OVF : SP_CAUSE_UDF;
      else if (sel && clr_fault) fault_ovf <= SP_CAUSE_UDF;
    end
endmodule

// File: rtl/banked_sp_reg.sv
// banked_sp_reg: multi-bank stack pointer with bank muxing, trap output and tri-state bus drivers
module banked_sp_reg
  import sp_pkg::*;
#(
  parameter int              SIZE          = 32,
  parameter int              BANKS         = 2,
  parameter int              STEP          = 1,
  parameter logic [SIZE-1:0] INITIAL_VAL   = '0,
  parameter logic [SIZE-1:0] INITIAL_LIMIT = '0
) (
  input  logic              clk,
  input  logic              rst,
  banked_sp_reg_if.slave    bus,
  output tri   [SIZE-1:0]   a,
  output tri   [SIZE-1:0]   b
);
  localparam int SW = SP_SEL_W(BANKS);
  logic [1:0] rst_q;
  logic rst_s;
  logic [SIZE-1:0] ptr [BANKS];
  logic [BANKS-1:0] hit, trap_v, fault_v, ovf_v;
  logic [SIZE-1:0] sel_ptr, value;
  assign rst_s = rst_q[1];
  // reset asserts immediately and releases two clocks later, aligned to clk
  always_ff @(posedge clk or posedge rst)
    if (rst) rst_q <= 2'b11;
    else rst_q <= {rst_q[0], 1'b0};
  for (genvar i = 0; i < BANKS; i++) begin : g_bank
    assign hit[i] = bus.bank_sel == SW'(i);
    sp_bank #(
      .SIZE(SIZE), .STEP(STEP), .INITIAL_VAL(INITIAL_VAL), .INITIAL_LIMIT(INITIAL_LIMIT)
    ) u_bank (
      .clk(clk), .rst(rst_s), .sel(hit[i]), .in(bus.in), .ld(bus.ld), .ld_limit(bus.ld_limit),
      .post_inc(bus.post_inc), .pre_dec(bus.pre_dec), .clr_fault(bus.clr_fault),
      .ptr(ptr[i]), .trap(trap_v[i]), .fault(fault_v[i]), .fault_ovf(ovf_v[i])
    );
  end
  // select the addressed bank's pointer; an out-of-range select reads as zero
  always_comb begin
    sel_ptr = '0;
    for (int k = 0; k < BANKS; k++) sel_ptr = hit[k] ? ptr[k] : sel_ptr;
  end
  assign value = |hit ? sel_ptr - (bus.pre_dec ? SIZE'(STEP) : '0) : '0;
  assign bus.value = value;
  assign bus.trap = |trap_v;
  assign bus.fault = fault_v;
  assign bus.fault_ovf = ovf_v;
  assign a = bus.oe_a ? value : 'z;
  assign b = bus.oe_b ? value : 'z;
endmodule
